semafor_auto_temporizat: RTL and testbench

- Single-approach vehicle signal-head controller with internal phase timers. Parametrised successor of the fixed-code light decoder.
- Sequences red -> green -> yellow -> all-red clearance autonomously from a shared time-base tick.
- Honours minimum green and adds a night blinking-yellow mode.
- Sits between the intersection arbiter (request/yield/clear handshake) and the lamp drivers of one approach; one instance per approach.

---
 rtl/semafor_auto_temporizat.sv | 146 ++++++++++++++
 tb/tb_semafor_auto_temporizat.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/semafor_auto_temporizat.sv
// Vehicle signal head for one approach. Runs red -> green -> yellow ->
// all-red clearance from a shared tick, enforces a minimum green and
// offers a night blinking-yellow mode.
module semafor_auto_temporizat #(
    parameter int CNT_W        = 8,
    parameter int T_VERDE_MIN  = 10,
    parameter int T_GALBEN     = 3,
    parameter int T_ROSU_TOTAL = 2,
    parameter int T_BLINK      = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic             cerere_verde_i,
    input  logic             cedare_i,
    input  logic             mod_noapte_i,
    output logic             Rosu_auto_o,
    output logic             Galben_auto_o,
    output logic             Verde_auto_o,
    output logic             liber_o,
    output logic [2:0]       stare_o,
    output logic [CNT_W-1:0] timp_ramas_o
);

    typedef enum logic [2:0] {
        ROSU       = 3'b000,
        VERDE      = 3'b001,
        GALBEN     = 3'b010,
        ROSU_TOTAL = 3'b011,
        NOAPTE     = 3'b100
    } stare_t;

    localparam logic [CNT_W-1:0] LD_VERDE  = CNT_W'(T_VERDE_MIN);
    localparam logic [CNT_W-1:0] LD_GALBEN = CNT_W'(T_GALBEN);
    localparam logic [CNT_W-1:0] LD_RT     = CNT_W'(T_ROSU_TOTAL);
    localparam logic [CNT_W-1:0] LD_BLINK  = CNT_W'(T_BLINK);

    stare_t           stare_q, stare_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             blink_q, blink_d;
    logic             timer_zero;

    assign timer_zero = (timer_q == '0);

    // State, phase timer and blink phase; everything freezes while disabled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stare_q <= ROSU;
            timer_q <= '0;
            blink_q <= 1'b0;
        end else if (enable_i) begin
            stare_q <= stare_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

    // Next state: timer counts down on ticks, phase changes reload it.
    // Exits are taken as soon as the timer reads zero, without a tick.
    always_comb begin
        stare_d = stare_q;
        blink_d = blink_q;
        timer_d = timer_q;
        if (tick_i && !timer_zero) timer_d = timer_q - 1'b1;
        case (stare_q)
            ROSU: begin
                if (mod_noapte_i) begin
                    stare_d = NOAPTE;
                    timer_d = LD_BLINK;
                end else if (cerere_verde_i) begin
                    stare_d = VERDE;
                    timer_d = LD_VERDE;
                end
            end
            VERDE: begin
                // Yield only once minimum green has elapsed; an early
                // cedare_i pulse is deliberately forgotten.
                if (timer_zero && (cedare_i || mod_noapte_i)) begin
                    stare_d = GALBEN;
                    timer_d = LD_GALBEN;
                end
            end
            GALBEN: begin
                if (timer_zero) begin
                    stare_d = ROSU_TOTAL;
                    timer_d = LD_RT;
                end
            end
            ROSU_TOTAL: begin
                if (timer_zero) begin
                    if (mod_noapte_i) begin
                        stare_d = NOAPTE;
                        timer_d = LD_BLINK;
                    end else begin
                        stare_d = ROSU;
                    end
                end
            end
            NOAPTE: begin
                // Leaving night mode always passes through clearance.
                if (!mod_noapte_i) begin
                    stare_d = ROSU_TOTAL;
                    timer_d = LD_RT;
                    blink_d = 1'b0;
                end else if (timer_zero) begin
                    timer_d = LD_BLINK;
                    blink_d = ~blink_q;
                end
            end
            default: begin
                // Corrupted code: fall back to a full clearance interval.
                stare_d = ROSU_TOTAL;
                timer_d = LD_RT;
                blink_d = 1'b0;
            end
        endcase
    end

    // Lamp decode; any non-driving state shows red.
    always_comb begin
        Rosu_auto_o   = 1'b1;
        Galben_auto_o = 1'b0;
        Verde_auto_o  = 1'b0;
        case (stare_q)
            VERDE: begin
                Rosu_auto_o  = 1'b0;
                Verde_auto_o = 1'b1;
            end
            GALBEN: begin
                Rosu_auto_o   = 1'b0;
                Galben_auto_o = 1'b1;
            end
            NOAPTE: begin
                Rosu_auto_o   = 1'b0;
                Galben_auto_o = blink_q;
            end
            default: Rosu_auto_o = 1'b1;
        endcase
    end

    assign liber_o      = (stare_q == ROSU);
    assign stare_o      = stare_q;
    assign timp_ramas_o = timer_q;

endmodule

// File: tb/tb_semafor_auto_temporizat.sv
// Bench for semafor_auto_temporizat: directed scenarios plus a random run
// compared each cycle against a phase/remaining-time reference model.
module tb_semafor_auto_temporizat;

    localparam int CNT_W = 8;
    localparam int T_VM  = 10;
    localparam int T_G   = 3;
    localparam int T_RT  = 2;
    localparam int T_BL  = 1;
    localparam int OW    = 7 + CNT_W;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    logic enable_i = 1'b0, tick_i = 1'b0, cerere_verde_i = 1'b0;
    logic cedare_i = 1'b0, mod_noapte_i = 1'b0;
    logic Rosu_auto_o, Galben_auto_o, Verde_auto_o, liber_o;
    logic [2:0] stare_o;
    logic [CNT_W-1:0] timp_ramas_o;
    logic [OW-1:0] obs;

    int passed = 0;
    int total  = 0;

    semafor_auto_temporizat #(
        .CNT_W(CNT_W), .T_VERDE_MIN(T_VM), .T_GALBEN(T_G),
        .T_ROSU_TOTAL(T_RT), .T_BLINK(T_BL)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .tick_i(tick_i),
        .cerere_verde_i(cerere_verde_i), .cedare_i(cedare_i),
        .mod_noapte_i(mod_noapte_i), .Rosu_auto_o(Rosu_auto_o),
        .Galben_auto_o(Galben_auto_o), .Verde_auto_o(Verde_auto_o),
        .liber_o(liber_o), .stare_o(stare_o), .timp_ramas_o(timp_ramas_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {Rosu_auto_o, Galben_auto_o, Verde_auto_o, liber_o, stare_o, timp_ramas_o};

    // Expected output word: lamps R,Y,G, liber, state code, remaining ticks.
    function automatic logic [OW-1:0] mk(bit r, bit y, bit g, bit l, int st, int tm);
        return {r, y, g, l, 3'(st), CNT_W'(tm)};
    endfunction

    // Reference model: which phase the approach is in, how many ticks remain,
    // and whether the night lamp is lit.
    typedef enum int {PH_RED, PH_GO, PH_AMBER, PH_CLEAR, PH_BLINK} ph_t;
    typedef struct {
        ph_t ph;
        int  rem;
        bit  lit;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_next(mdl_t c, bit tick, bit cer, bit ced, bit noa);
        mdl_t n = c;
        bit   moved = 1'b1;
        bit   up    = (c.rem == 0);
        if (c.ph == PH_RED && noa)                     begin n.ph = PH_BLINK; n.rem = T_BL; end
        else if (c.ph == PH_RED && cer)                begin n.ph = PH_GO;    n.rem = T_VM; end
        else if (c.ph == PH_GO && up && (ced || noa))  begin n.ph = PH_AMBER; n.rem = T_G;  end
        else if (c.ph == PH_AMBER && up)               begin n.ph = PH_CLEAR; n.rem = T_RT; end
        else if (c.ph == PH_CLEAR && up)               begin n.ph = noa ? PH_BLINK : PH_RED; n.rem = noa ? T_BL : 0; end
        else if (c.ph == PH_BLINK && !noa)             begin n.ph = PH_CLEAR; n.rem = T_RT; n.lit = 1'b0; end
        else if (c.ph == PH_BLINK && up)               begin n.rem = T_BL; n.lit = !c.lit; end
        else moved = 1'b0;
        // Nothing happened: time simply passes.
        if (!moved && tick && c.rem > 0) n.rem = c.rem - 1;
        return n;
    endfunction

    function automatic logic [OW-1:0] model_out(mdl_t c);
        case (c.ph)
            PH_RED:   return mk(1, 0, 0, 1, 0, c.rem);
            PH_GO:    return mk(0, 0, 1, 0, 1, c.rem);
            PH_AMBER: return mk(0, 1, 0, 0, 2, c.rem);
            PH_CLEAR: return mk(1, 0, 0, 0, 3, c.rem);
            default:  return mk(0, c.lit, 0, 0, 4, c.rem);
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) m <= '{PH_RED, 0, 1'b0};
        else if (enable_i) m <= model_next(m, tick_i, cerere_verde_i, cedare_i, mod_noapte_i);
    end

    // One clock with the given tick level; returns on the next falling edge.
    task automatic cyc(input bit t);
        tick_i = t;
        @(negedge clk_i);
        tick_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL reset: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
        cerere_verde_i = 1'b1; cyc(1); cerere_verde_i = 1'b0;
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL reset_disabled: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
    endtask

    task automatic test_green_cycle();
        enable_i = 1'b1; cerere_verde_i = 1'b1; cyc(0); cerere_verde_i = 1'b0;
        total++; if (obs !== mk(0,0,1,0,1,10)) $display("FAIL enter_green: got %h want %h", obs, mk(0,0,1,0,1,10)); else passed++;
        cedare_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin cyc(0); cyc(0); cyc(0); end
            cyc(1);
        end
        total++; if (obs !== mk(0,0,1,0,1,0)) $display("FAIL green_timer_zero: got %h want %h", obs, mk(0,0,1,0,1,0)); else passed++;
        cyc(0);
        total++; if (obs !== mk(0,1,0,0,2,3)) $display("FAIL enter_yellow: got %h want %h", obs, mk(0,1,0,0,2,3)); else passed++;
        for (int i = 0; i < 3; i++) begin cyc(1); cyc(0); end
        total++; if (obs !== mk(1,0,0,0,3,2)) $display("FAIL enter_clear: got %h want %h", obs, mk(1,0,0,0,3,2)); else passed++;
        for (int i = 0; i < 2; i++) begin cyc(1); cyc(0); end
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL back_to_red: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
        cedare_i = 1'b0;
    endtask

    task automatic test_min_green();
        cerere_verde_i = 1'b1; cedare_i = 1'b1; cyc(0); cerere_verde_i = 1'b0; cedare_i = 1'b0;
        total++; if (obs !== mk(0,0,1,0,1,10)) $display("FAIL simult_req_yield: got %h want %h", obs, mk(0,0,1,0,1,10)); else passed++;
        for (int i = 0; i < 5; i++) cyc(1);
        cedare_i = 1'b1; cyc(0); cedare_i = 1'b0;
        total++; if (obs !== mk(0,0,1,0,1,5)) $display("FAIL early_yield_ignored: got %h want %h", obs, mk(0,0,1,0,1,5)); else passed++;
        for (int i = 0; i < 5; i++) cyc(1);
        for (int i = 0; i < 3; i++) cyc(0);
        total++; if (obs !== mk(0,0,1,0,1,0)) $display("FAIL yield_not_latched: got %h want %h", obs, mk(0,0,1,0,1,0)); else passed++;
        cedare_i = 1'b1; cyc(0); cedare_i = 1'b0;
        total++; if (obs !== mk(0,1,0,0,2,3)) $display("FAIL late_yield: got %h want %h", obs, mk(0,1,0,0,2,3)); else passed++;
        for (int i = 0; i < 7; i++) cyc(1);
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL min_green_return: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
    endtask

    task automatic test_night();
        mod_noapte_i = 1'b1; cerere_verde_i = 1'b1; cyc(0); cerere_verde_i = 1'b0;
        total++; if (obs !== mk(0,0,0,0,4,1)) $display("FAIL enter_night: got %h want %h", obs, mk(0,0,0,0,4,1)); else passed++;
        cyc(1);
        total++; if (obs !== mk(0,0,0,0,4,0)) $display("FAIL night_tick1: got %h want %h", obs, mk(0,0,0,0,4,0)); else passed++;
        cyc(0);
        total++; if (obs !== mk(0,1,0,0,4,1)) $display("FAIL blink_on: got %h want %h", obs, mk(0,1,0,0,4,1)); else passed++;
        cyc(1); cyc(0);
        total++; if (obs !== mk(0,0,0,0,4,1)) $display("FAIL blink_off: got %h want %h", obs, mk(0,0,0,0,4,1)); else passed++;
        cyc(1); cyc(0);
        mod_noapte_i = 1'b0; cyc(1);
        total++; if (obs !== mk(1,0,0,0,3,2)) $display("FAIL night_exit: got %h want %h", obs, mk(1,0,0,0,3,2)); else passed++;
        cyc(1); cyc(1); cyc(0);
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL night_to_red: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
    endtask

    task automatic test_enable_freeze();
        cerere_verde_i = 1'b1; cyc(0); cerere_verde_i = 1'b0; cedare_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1);
        cyc(0); cyc(1);
        total++; if (obs !== mk(0,1,0,0,2,2)) $display("FAIL yellow_t2: got %h want %h", obs, mk(0,1,0,0,2,2)); else passed++;
        enable_i = 1'b0; mod_noapte_i = 1'b1;
        for (int i = 0; i < 5; i++) begin cyc(1); cyc(0); end
        total++; if (obs !== mk(0,1,0,0,2,2)) $display("FAIL frozen: got %h want %h", obs, mk(0,1,0,0,2,2)); else passed++;
        enable_i = 1'b1; mod_noapte_i = 1'b0; cyc(1); cyc(1);
        total++; if (obs !== mk(0,1,0,0,2,0)) $display("FAIL resume_t0: got %h want %h", obs, mk(0,1,0,0,2,0)); else passed++;
        cyc(0);
        total++; if (obs !== mk(1,0,0,0,3,2)) $display("FAIL resume_exit: got %h want %h", obs, mk(1,0,0,0,3,2)); else passed++;
        cedare_i = 1'b0; cyc(1); cyc(1); cyc(0);
    endtask

    task automatic test_async_reset();
        cerere_verde_i = 1'b1; cyc(0); cerere_verde_i = 1'b0; cyc(1); cyc(1);
        total++; if (obs !== mk(0,0,1,0,1,8)) $display("FAIL pre_reset_green: got %h want %h", obs, mk(0,0,1,0,1,8)); else passed++;
        #2 rst_n_i = 1'b0;
        #1;
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL async_reset: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
        @(negedge clk_i); rst_n_i = 1'b1; cyc(1);
        total++; if (obs !== mk(1,0,0,1,0,0)) $display("FAIL after_reset: got %h want %h", obs, mk(1,0,0,1,0,0)); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            enable_i       = ($urandom_range(0, 7) != 0);
            cerere_verde_i = ($urandom_range(0, 3) == 0);
            cedare_i       = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) mod_noapte_i = ~mod_noapte_i;
            cyc($urandom_range(0, 2) == 0);
            total++;
            if (obs !== model_out(m))
                $display("FAIL random_cycle %0d: got %h want %h", i, obs, model_out(m));
            else passed++;
        end
        enable_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_green_cycle();
        test_min_green();
        test_night();
        test_enable_freeze();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
